// File: rtl/sine_arb_pkg.sv
// rtl/sine_arb_pkg.sv - shared defaults, quadrant codes and pointer helper for the sine ROM arbiter
package sine_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 12;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  function automatic int next_ptr(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with its rotating priority pointer
module rr_arbiter
  import sine_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_pix,
  input  logic         resetn,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] g_idx;
  logic             found;

  // Scan upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    grant = '0;
    idx   = '0;
    g_idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        g_idx = idx;
      end
    end
    if (found) grant[g_idx] = 1'b1;
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= PTR_W'(next_ptr(int'(g_idx), N));
    end
  end

endmodule

// File: rtl/sine_rom_arbiter.sv
// rtl/sine_rom_arbiter.sv - round-robin shared sine ROM lookup, 2-cycle pipeline; SINE_ROM_ARBITER_FOLD_EN enables quarter-wave folding
module sine_rom_arbiter
  import sine_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PHASE_W = ADDR_W + 2
) (
  input  logic                     clk_pix,
  input  logic                     resetn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*PHASE_W-1:0] req_phase,
  output logic [N_REQ-1:0]         req_ready,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data
);

  logic [PHASE_W-1:0] sel_phase;
  logic [ADDR_W-1:0]  map_addr;
  logic [N_REQ-1:0]   s1_tag;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_pix (clk_pix),
    .resetn  (resetn),
    .req     (req_valid),
    .grant   (req_ready)
  );

  always_comb begin
    sel_phase = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) sel_phase = req_phase[i*PHASE_W +: PHASE_W];
    end
  end

`ifdef SINE_ROM_ARBITER_FOLD_EN
  logic [1:0] sel_q;
  logic [1:0] s1_q;

  // Odd quadrants walk the quarter wave backwards; lower half-cycle negates.
  always_comb begin
    sel_q    = sel_phase[PHASE_W-1:PHASE_W-2];
    map_addr = sel_phase[ADDR_W-1:0];
    if (sel_q == Q1 || sel_q == Q3) map_addr = ~sel_phase[ADDR_W-1:0];
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      s1_q <= Q0;
    end else begin
      s1_q <= sel_q;
    end
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      rsp_data <= '0;
    end else if (|s1_tag) begin
      rsp_data <= (s1_q == Q2 || s1_q == Q3) ? -rom_data : rom_data;
    end
  end
`else
  logic unused_phase_hi;

  assign map_addr        = sel_phase[ADDR_W-1:0];
  assign unused_phase_hi = ^sel_phase[PHASE_W-1:ADDR_W];

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      rsp_data <= '0;
    end else if (|s1_tag) begin
      rsp_data <= rom_data;
    end
  end
`endif

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      rom_addr  <= '0;
      s1_tag    <= '0;
      rsp_valid <= '0;
    end else begin
      if (|req_ready) rom_addr <= map_addr;
      s1_tag    <= req_ready;
      rsp_valid <= s1_tag;
    end
  end

endmodule

// File: tb/tb_sine_rom_arbiter.sv
// tb/tb_sine_rom_arbiter.sv - scoreboard bench for sine_rom_arbiter against a table-based reference
module tb_sine_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 12;
  localparam int PW = 11;

  logic            clk_pix = 1'b0;
  logic            resetn;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_phase;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;

  sine_rom_arbiter dut (
    .clk_pix   (clk_pix),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_phase (req_phase),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clk_pix = ~clk_pix;

  logic [DW-1:0] rom_mem [512];
  assign rom_data = rom_mem[rom_addr];

  typedef struct {
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            mptr  = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] hold_data = '0;
  logic          pend [N];
  logic [PW-1:0] ph   [N];
  int            gcount [N];
  logic [N-1:0]  last_ready;

  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] ref_addr(input logic [PW-1:0] p);
`ifdef SINE_ROM_ARBITER_FOLD_EN
    logic [1:0] q;
    q = p[PW-1:PW-2];
    return (q == 2'd1 || q == 2'd3) ? ~p[AW-1:0] : p[AW-1:0];
`else
    return p[AW-1:0];
`endif
  endfunction

  function automatic logic [DW-1:0] ref_data(input logic [PW-1:0] p);
    logic [DW-1:0] d;
    d = rom_mem[ref_addr(p)];
`ifdef SINE_ROM_ARBITER_FOLD_EN
    if (p[PW-1:PW-2] >= 2'd2) d = DW'(0) - d;
`endif
    return d;
  endfunction

  task automatic step();
    int   gi;
    int   idx;
    logic [N-1:0] eg;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pend[i];
      req_phase[i*PW +: PW]   = ph[i];
    end
    @(negedge clk_pix);
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    gi = -1;
    eg = '0;
    for (int k = 0; k < N; k++) begin
      idx = (mptr + k) % N;
      if (gi < 0 && pend[idx]) gi = idx;
    end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(eg));
    last_ready = req_ready;
    if (gi >= 0) begin
      e.tag  = eg;
      e.data = ref_data(ph[gi]);
      e.due  = cyc + 2;
      sb.push_back(e);
      exp_addr = ref_addr(ph[gi]);
      mptr     = (gi + 1) % N;
      pend[gi] = 1'b0;
      gcount[gi]++;
    end
    @(posedge clk_pix);
    #1;
  endtask

  // Monitor: pops an expectation whenever one falls due, otherwise demands silence.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_pix);
      if (resetn === 1'b1) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(e.tag));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          hold_data = e.data;
        end else begin
          chk("rsp_idle_valid", 32'(rsp_valid), 32'd0);
          chk("rsp_hold_data", 32'(rsp_data), 32'(hold_data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 512; a++) rom_mem[a] = DW'($urandom);
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; ph[i] = '0; gcount[i] = 0;
    end
    resetn    = 1'b0;
    req_valid = '0;
    req_phase = '0;
    repeat (2) @(posedge clk_pix);
    #1;
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    resetn = 1'b1;

    // single lookup from requester 0
    pend[0] = 1'b1; ph[0] = 11'd100;
    step();
    chk("single_ready", 32'(last_ready), 32'b0001);
    chk("single_addr", 32'(rom_addr), 32'd100);
    repeat (3) step();

    // all four requesting continuously for 12 cycles
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin pend[i] = 1'b1; ph[i] = PW'($urandom); end
      step();
    end
    for (int i = 0; i < N; i++) chk("fair_count", 32'(gcount[i]), 32'd3);
    repeat (4) step();

    // move pointer to 2, then requesters 1 and 3 contend
    pend[1] = 1'b1; ph[1] = PW'($urandom);
    step();
    pend[1] = 1'b1; ph[1] = PW'($urandom);
    pend[3] = 1'b1; ph[3] = PW'($urandom);
    step();
    chk("rr13_first", 32'(last_ready), 32'b1000);
    pend[3] = 1'b1; ph[3] = PW'($urandom);
    step();
    chk("rr13_second", 32'(last_ready), 32'b0010);
    step();
    chk("rr13_third", 32'(last_ready), 32'b1000);
    repeat (3) step();

    // quadrant phases through requester 2
    pend[2] = 1'b1; ph[2] = 11'b10_000001010;
    step();
    chk("phase_q2_addr", 32'(rom_addr), 32'd10);
    pend[2] = 1'b1; ph[2] = 11'b01_000001010;
    step();
`ifdef SINE_ROM_ARBITER_FOLD_EN
    chk("phase_q1_addr", 32'(rom_addr), 32'd501);
`else
    chk("phase_q1_addr", 32'(rom_addr), 32'd10);
`endif
    repeat (3) step();

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          pend[i] = 1'b1; ph[i] = PW'($urandom);
        end
      step();
    end
    while (pend[0] || pend[1] || pend[2] || pend[3]) step();
    repeat (3) step();

    // reset with two lookups in flight
    pend[0] = 1'b1; ph[0] = PW'($urandom);
    pend[1] = 1'b1; ph[1] = PW'($urandom);
    step();
    step();
    #2;
    resetn    = 1'b0;
    req_valid = '0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    sb.delete();
    mptr = 0; exp_addr = '0; hold_data = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (2) @(posedge clk_pix);
    #1;
    resetn = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; ph[i] = PW'($urandom); end
    step();
    chk("post_rst_ptr", 32'(last_ready), 32'b0001);
    while (pend[0] || pend[1] || pend[2] || pend[3]) step();
    repeat (4) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
